// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the dual-port data memory.
// Imported by the memory top and its read pipeline.
package soc_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int RD_LAT_COMB = 1;
  localparam int RD_LAT_REG  = 2;

endpackage

// File: rtl/soc_mem_rdpipe.sv
// Read-return delay line: RD_LAT stages of valid plus data.
// Data stages only load when a valid word arrives, so q holds the last read.
module soc_mem_rdpipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 0; k < RD_LAT; k++) dat[k] <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int k = 1; k < RD_LAT; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  // A valid held across a stall is shown once the block runs again.
  assign out_valid = vld[RD_LAT-1] & en;
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/soc_data_mem_dp.sv
// True dual-port byte-enabled data memory with Avalon-MM slave ports.
// Optional zero-fill sweep after reset; read-first on every collision.
module soc_data_mem_dp
  import soc_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_chipselect,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  output logic                a_waitrequest,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_chipselect,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                b_waitrequest
);

  localparam int NB  = DATA_W / 8;
  localparam int LAT = (RD_LAT >= RD_LAT_REG) ? RD_LAT_REG : RD_LAT_COMB;

  mem_state_e        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic stall;
  logic a_acc, a_we, a_re;
  logic b_acc, b_we, b_re;

  assign stall = !reset_n || !clken || (state != READY);

  assign a_waitrequest = stall;
  assign b_waitrequest = stall;

  assign a_acc = a_chipselect & (a_read | a_write) & !stall;
  assign b_acc = b_chipselect & (b_read | b_write) & !stall;
  assign a_we  = a_acc & a_write;
  assign b_we  = b_acc & b_write;
  assign a_re  = a_acc & a_read & !a_write;
  assign b_re  = b_acc & b_read & !b_write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr <= '0;
    end else if (clken && state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == ADDR_W'(DEPTH - 1)) state <= READY;
    end
  end

  // Port b lanes go first so port a overrides lanes both ports enable.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state == CLEAR && reset_n) begin
        mem[clr_addr] <= '0;
      end else begin
        for (int l = 0; l < NB; l++)
          if (b_we && b_byteenable[l])
            mem[b_address][l*8 +: 8] <= b_writedata[l*8 +: 8];
        for (int l = 0; l < NB; l++)
          if (a_we && a_byteenable[l])
            mem[a_address][l*8 +: 8] <= a_writedata[l*8 +: 8];
      end
    end
  end

  soc_mem_rdpipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_rdpipe_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clken),
    .in_valid (a_re),
    .in_data  (mem[a_address]),
    .out_valid(a_readdatavalid),
    .out_data (a_readdata)
  );

  soc_mem_rdpipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_rdpipe_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clken),
    .in_valid (b_re),
    .in_data  (mem[b_address]),
    .out_valid(b_readdatavalid),
    .out_data (b_readdata)
  );

endmodule

// File: tb/tb_soc_data_mem_dp.sv
// Bench: two memory instances (2048 words/lat 1/clear, 256 words/lat 2/no clear)
// checked every cycle against a word-level model, plus literal scenarios.
module tb_soc_data_mem_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        ce    [2];
  logic        cs    [2][2];
  logic        rd    [2][2];
  logic        wr    [2][2];
  logic [10:0] ad    [2][2];
  logic [3:0]  be    [2][2];
  logic [31:0] wd    [2][2];
  logic [31:0] q     [2][2];
  logic        v     [2][2];
  logic        w     [2][2];

  int ncmp = 0;
  int nbad = 0;

  soc_data_mem_dp #(.DATA_W(32), .DEPTH(2048), .RD_LAT(1),
                    .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .clken(ce[0]),
    .a_address(ad[0][0]), .a_chipselect(cs[0][0]), .a_read(rd[0][0]),
    .a_write(wr[0][0]), .a_byteenable(be[0][0]), .a_writedata(wd[0][0]),
    .a_readdata(q[0][0]), .a_readdatavalid(v[0][0]), .a_waitrequest(w[0][0]),
    .b_address(ad[0][1]), .b_chipselect(cs[0][1]), .b_read(rd[0][1]),
    .b_write(wr[0][1]), .b_byteenable(be[0][1]), .b_writedata(wd[0][1]),
    .b_readdata(q[0][1]), .b_readdatavalid(v[0][1]), .b_waitrequest(w[0][1])
  );

  soc_data_mem_dp #(.DATA_W(32), .DEPTH(256), .RD_LAT(2),
                    .CLEAR_ON_RESET(0)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .clken(ce[1]),
    .a_address(ad[1][0][7:0]), .a_chipselect(cs[1][0]), .a_read(rd[1][0]),
    .a_write(wr[1][0]), .a_byteenable(be[1][0]), .a_writedata(wd[1][0]),
    .a_readdata(q[1][0]), .a_readdatavalid(v[1][0]), .a_waitrequest(w[1][0]),
    .b_address(ad[1][1][7:0]), .b_chipselect(cs[1][1]), .b_read(rd[1][1]),
    .b_write(wr[1][1]), .b_byteenable(be[1][1]), .b_writedata(wd[1][1]),
    .b_readdata(q[1][1]), .b_readdatavalid(v[1][1]), .b_waitrequest(w[1][1])
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mm [2][2048];
  rd_t         rq [4][$];
  int unsigned eidx    [2] = '{0, 0};
  int          clr_cnt [2] = '{0, 0};
  bit          started [2] = '{0, 0};

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int depth(input int i);
    return (i == 0) ? 2048 : 256;
  endfunction

  function automatic bit clears(input int i);
    return (i == 0);
  endfunction

  function automatic bit ready(input int i);
    return !clears(i) || (clr_cnt[i] >= depth(i));
  endfunction

  function automatic int maddr(input int i, input int p);
    return int'(ad[i][p]) % depth(i);
  endfunction

  bit          m_rdy;
  int          m_a   [2];
  logic [31:0] m_old [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        started[i] = 1'b1;
        for (int p = 0; p < 2; p++) rq[i*2+p].delete();
        clr_cnt[i] = 0;
        if (clears(i))
          for (int k = 0; k < 2048; k++) mm[i][k] = '0;
      end else if (ce[i]) begin
        m_rdy = ready(i);
        for (int p = 0; p < 2; p++)
          if (rq[i*2+p].size() != 0 && rq[i*2+p][0].due == eidx[i])
            void'(rq[i*2+p].pop_front());
        eidx[i]++;
        for (int p = 0; p < 2; p++) begin
          m_a[p]   = maddr(i, p);
          m_old[p] = mm[i][m_a[p]];
        end
        if (m_rdy) begin
          for (int p = 0; p < 2; p++)
            if (cs[i][p] && rd[i][p] && !wr[i][p])
              rq[i*2+p].push_back('{eidx[i] + lat(i) - 1, m_old[p]});
          for (int p = 1; p >= 0; p--)
            if (cs[i][p] && wr[i][p])
              for (int l = 0; l < 4; l++)
                if (be[i][p][l]) mm[i][m_a[p]][l*8 +: 8] = wd[i][p][l*8 +: 8];
        end else begin
          clr_cnt[i]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit c_w, c_v;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        for (int p = 0; p < 2; p++) begin
          c_w = !rst_n[i] || !ce[i] || !ready(i);
          c_v = ce[i] && rq[i*2+p].size() != 0 &&
                rq[i*2+p][0].due == eidx[i];
          chk($sformatf("i%0d p%0d waitrequest", i, p), 64'(w[i][p]),
              64'(c_w));
          chk($sformatf("i%0d p%0d readdatavalid", i, p), 64'(v[i][p]),
              64'(c_v));
          if (c_v)
            chk($sformatf("i%0d p%0d readdata", i, p), 64'(q[i][p]),
                64'(rq[i*2+p][0].d));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    for (int p = 0; p < 2; p++) begin
      cs[i][p] = 1'b0;
      rd[i][p] = 1'b0;
      wr[i][p] = 1'b0;
    end
  endtask

  task automatic setw(input int i, input int p, input int a,
                      input logic [31:0] d, input logic [3:0] m);
    cs[i][p] = 1'b1;
    wr[i][p] = 1'b1;
    rd[i][p] = 1'b0;
    ad[i][p] = 11'(a);
    wd[i][p] = d;
    be[i][p] = m;
  endtask

  task automatic setr(input int i, input int p, input int a);
    cs[i][p] = 1'b1;
    rd[i][p] = 1'b1;
    wr[i][p] = 1'b0;
    ad[i][p] = 11'(a);
  endtask

  task automatic wrw(input int i, input int p, input int a,
                     input logic [31:0] d, input logic [3:0] m);
    setw(i, p, a, d, m);
    tick();
    idle(i);
  endtask

  task automatic wait_rd(input int i, input int p, input logic [31:0] exp,
                         input string nm);
    int n;
    n = 1;
    while (n <= 8) begin
      @(negedge clk);
      if (v[i][p]) break;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat(i)));
    if (n <= 8) chk({nm, " data"}, 64'(q[i][p]), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic rd_lit(input int i, input int p, input int a,
                        input logic [31:0] exp, input string nm);
    setr(i, p, a);
    tick();
    idle(i);
    wait_rd(i, p, exp, nm);
  endtask

  task automatic wait_clear(input int i, input string nm);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!w[i][0]) break;
      n++;
    end
    chk(nm, 64'(n), 64'd2048);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int i, input int n);
    repeat (n) begin
      ce[i] = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < 2; p++) begin
        cs[i][p] = ($urandom_range(0, 3) != 0);
        rd[i][p] = 1'($urandom_range(0, 1));
        wr[i][p] = 1'($urandom_range(0, 1));
        ad[i][p] = 11'($urandom_range(0, 15));
        be[i][p] = 4'($urandom);
        wd[i][p] = $urandom;
      end
      tick();
    end
    idle(i);
    ce[i] = 1'b1;
    repeat (4) tick();
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] got [$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      ce[i]    = 1'b1;
      for (int p = 0; p < 2; p++) begin
        cs[i][p] = 1'b0; rd[i][p] = 1'b0; wr[i][p] = 1'b0;
        ad[i][p] = '0;   be[i][p] = '0;   wd[i][p] = '0;
      end
    end
    repeat (3) tick();
    @(negedge clk);
    chk("reset q0a", 64'(q[0][0]), 64'd0);
    chk("reset v1b", 64'(v[1][1]), 64'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // instance 0: clear sweep, byte lanes, collisions
    wait_clear(0, "clear length");
    rd_lit(0, 0, 11'h7FF, 32'h0, "clr 7ff");
    wrw(0, 0, 5, 32'hDEADBEEF, 4'hF);
    wrw(0, 0, 5, 32'h00001100, 4'h2);
    rd_lit(0, 0, 5, 32'hDEAD11EF, "be merge l1");
    wrw(0, 0, 9, 32'h22000000, 4'hF);
    setw(0, 0, 9, 32'h11111111, 4'h3);
    setw(0, 1, 9, 32'h22222222, 4'h6);
    tick();
    idle(0);
    rd_lit(0, 1, 9, 32'h22221111, "dual write");
    wrw(0, 1, 3, 32'h12345678, 4'hF);
    setw(0, 0, 3, 32'hAAAA0000, 4'hF);
    setr(0, 1, 3);
    tick();
    idle(0);
    wait_rd(0, 1, 32'h12345678, "cross read-first");
    rd_lit(0, 1, 3, 32'hAAAA0000, "read after");
    rnd(0, 2000);
    wrw(0, 0, 11'h7FF, 32'hFFFFFFFF, 4'hF);
    rst_n[0] = 1'b0;
    repeat (2) tick();
    rst_n[0] = 1'b1;
    repeat (100) tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    wait_clear(0, "clear restart length");
    rd_lit(0, 0, 11'h7FF, 32'h0, "reclear 7ff");

    // instance 1: no clear, two-cycle latency
    for (int k = 0; k < 256; k++)
      wrw(1, k % 2, k, 32'hC0DE0000 | 32'(k), 4'hF);
    wrw(1, 0, 5, 32'hDEADBEEF, 4'hF);
    wrw(1, 0, 5, 32'h00001100, 4'h2);
    rd_lit(1, 0, 5, 32'hDEAD11EF, "be merge l2");

    got.delete();
    fork
      begin
        setr(1, 1, 10); tick();
        ad[1][1] = 11'd11; tick();
        ce[1] = 1'b0; tick(); tick();
        ce[1] = 1'b1; ad[1][1] = 11'd12; tick();
        ad[1][1] = 11'd13; tick();
        idle(1);
        repeat (4) tick();
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!ce[1]) begin
            chk("stall wait", 64'(w[1][1]), 64'd1);
            chk("stall valid", 64'(v[1][1]), 64'd0);
          end
          if (v[1][1]) got.push_back(q[1][1]);
        end
      end
    join
    @(posedge clk);
    #1;
    chk("burst count", 64'(got.size()), 64'd4);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("burst %0d", k), 64'(got[k]),
          64'(32'hC0DE000A + 32'(k)));

    wrw(1, 0, 20, 32'h5A5A1234, 4'hF);
    setr(1, 0, 20); tick();
    ad[1][0] = 11'd21; tick();
    idle(1);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post-reset valid a", 64'(v[1][0]), 64'd0);
    end
    chk("post-reset q a", 64'(q[1][0]), 64'd0);
    @(posedge clk);
    #1;
    rd_lit(1, 0, 20, 32'h5A5A1234, "kept through reset");
    rnd(1, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/soc_data_mem_dp.md
SOC_DATA_MEM_DP -- requirements
Module: soc_data_mem_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter DEPTH, default 2048: number of words; power of two, 16..65536.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): word-address width.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 (unregistered q) and 2 (registered q).
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: zero-fill the array after reset.
REQ-006 SHALL have port clk, input, 1: single clock for the whole block.
REQ-007 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port clken, input, 1: global clock enable; when low, the block holds its state.
REQ-009 SHALL have, for each port p in {a, b}, p_address, input, ADDR_W: word address.
REQ-010 SHALL have p_chipselect, p_read and p_write, each input, 1: Avalon-MM slave request qualifiers.
REQ-011 SHALL have p_byteenable, input, DATA_W/8: byte-lane write mask.
REQ-012 SHALL have p_writedata, input, DATA_W: write data.
REQ-013 SHALL have p_readdata, output, DATA_W: read data.
REQ-014 SHALL have p_readdatavalid, output, 1: p_readdata valid this cycle.
REQ-015 SHALL have p_waitrequest, output, 1: request not accepted this cycle.

Function
REQ-016 SHALL accept a request on port p in a cycle where p_chipselect=1, p_read or p_write=1, p_waitrequest=0 and clken=1.
REQ-017 SHALL update only the lanes whose p_byteenable bit is 1 on an accepted write; a write with p_byteenable=0 changes nothing.
REQ-018 SHALL pulse p_readdatavalid for one cycle exactly RD_LAT cycles after an accepted read; back-to-back reads SHALL give back-to-back valids in order.
REQ-019 SHALL perform only the write when p_read and p_write are both 1, with no readdatavalid.
REQ-020 SHALL make a same-port read of an address written in the same cycle return the old data (read-first).
REQ-021 SHALL make a port-b read of an address port a writes in the same cycle (and vice versa) return the old data.
REQ-022 SHALL, when both ports write the same address in one cycle, merge per lane: port a wins on lanes enabled by both, and each port's other lanes apply.
REQ-023 SHALL, when clken=0, freeze the memory, the read pipelines, the FSM and all outputs, and drive p_waitrequest=1.
REQ-024 SHALL use FSM states CLEAR and READY.
REQ-025 SHALL leave reset in CLEAR when CLEAR_ON_RESET=1, otherwise in READY.
REQ-026 SHALL, in CLEAR, write zero to one word per enabled cycle from address 0 up to DEPTH-1, then go to READY; total time is DEPTH enabled cycles.
REQ-027 SHALL drive a_waitrequest=b_waitrequest=1 in CLEAR; in READY, p_waitrequest SHALL be 0 unless clken=0.
REQ-028 SHALL wrap the clear address counter only on the transition to READY; it is not reused afterwards.

Reset
REQ-029 SHALL, while reset_n=0 at a clk edge, clear p_readdata, p_readdatavalid and the read pipeline valids to 0, and set the FSM to CLEAR or READY per REQ-025.
REQ-030 SHALL drive p_waitrequest=1 during reset.
REQ-031 SHALL discard in-flight reads when reset is asserted mid-operation, with no readdatavalid after reset.
REQ-032 SHALL restart a clear sweep from address 0 when reset is asserted during CLEAR.
REQ-033 SHALL preserve memory contents through reset when CLEAR_ON_RESET=0.

Structure
REQ-034 SHALL put the FSM state enum (CLEAR, READY) and the legal RD_LAT constants in package soc_mem_pkg.
REQ-035 SHALL use one sub-module, soc_mem_rdpipe, holding the RD_LAT-deep valid/data delay line, instantiated once per port.
REQ-036 SHALL model the array behaviourally so that it infers true dual-port block RAM with byte enables; no vendor primitive SHALL be instantiated.

Verification
REQ-037 Reset release with CLEAR_ON_RESET=1, DEPTH=2048: waitrequest stays high for 2048 cycles, then drops; a read of 0x7FF returns 0.
REQ-038 Port a writes 0xDEADBEEF to addr 5 with be=0xF, then be=0x2 data 0x00001100; a read of addr 5 returns 0xDEAD11EF, with valid RD_LAT cycles later (checked for RD_LAT 1 and 2).
REQ-039 Same cycle: a writes 0x11111111 be=0x3 and b writes 0x22222222 be=0x6 to addr 9; a later read returns 0x22221111.
REQ-040 Port a writes 0xAAAA0000 to addr 3, which holds 0x12345678, while port b reads addr 3 in the same cycle: b gets 0x12345678; the next read gets 0xAAAA0000.
REQ-041 Four back-to-back reads on port b with clken low for 2 cycles mid-burst: 4 valids in order, none during the stall, waitrequest=1 during the stall.
REQ-042 reset_n=0 for 1 cycle with 2 reads in flight and CLEAR_ON_RESET=0: no readdatavalid afterwards, and earlier writes are still readable.
